// File: rtl/crosspoint_loader_if.sv
// Command channel between host-side logic and the crosspoint loader.
// Carries the valid/ready write handshake plus completion/error pulses.
interface crosspoint_loader_if #(
    parameter int ADDR_W = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_dat;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_addr, cmd_dat,
        input  cmd_ready, done, err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_dat,
        output cmd_ready, done, err
    );
endinterface

// File: rtl/crosspoint_loader.sv
// Serialises crosspoint cell writes into the 3-wire programming protocol:
// clear bit, ADDR_W address bits LSB first, then the data bit.
module crosspoint_loader #(
    parameter int CLK_DIV  = 4,
    parameter int ADDR_W   = 12,
    parameter int MAX_ADDR = 2351
) (
    input  logic                clk,
    input  logic                rst_n,
    crosspoint_loader_if.slave  cmd,
    output logic                xp_clk_,
    output logic                xp_dat,
    output logic                xp_clear
);
    localparam int BW = $clog2(ADDR_W + 2);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]     PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0]     B_LAST  = BW'(ADDR_W + 1);
    localparam logic [ADDR_W-1:0] MAX_A   = ADDR_W'(MAX_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t          state;
    logic [BW-1:0]   b;
    logic [PW-1:0]   ph;
    logic [ADDR_W:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            b             <= '0;
            ph            <= '0;
            sr            <= '0;
            cmd.cmd_ready <= 1'b1;
            cmd.done      <= 1'b0;
            cmd.err       <= 1'b0;
            xp_clk_       <= 1'b1;
            xp_dat        <= 1'b0;
            xp_clear      <= 1'b0;
        end else begin
            cmd.done <= 1'b0;
            cmd.err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        if (cmd.cmd_addr > MAX_A) begin
                            cmd.err <= 1'b1;
                        end else begin
                            state         <= HIGH;
                            b             <= '0;
                            ph            <= '0;
                            sr            <= {cmd.cmd_dat, cmd.cmd_addr};
                            cmd.cmd_ready <= 1'b0;
                            xp_clear      <= 1'b1;
                            xp_dat        <= 1'b0;
                        end
                    end
                end
                HIGH: begin
                    if (ph == PH_LAST) begin
                        state   <= LOW;
                        ph      <= '0;
                        xp_clk_ <= 1'b0;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                LOW: begin
                    if (ph == PH_LAST) begin
                        ph      <= '0;
                        xp_clk_ <= 1'b1;
                        if (b == B_LAST) begin
                            // frame complete: park lines at idle level
                            state         <= IDLE;
                            cmd.cmd_ready <= 1'b1;
                            cmd.done      <= 1'b1;
                            xp_clear      <= 1'b0;
                            xp_dat        <= 1'b0;
                        end else begin
                            // next bit: address LSB-first, data bit last
                            state    <= HIGH;
                            b        <= b + 1'b1;
                            xp_clear <= 1'b0;
                            xp_dat   <= sr[0];
                            sr       <= sr >> 1;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crosspoint_loader.sv
// Bench for crosspoint_loader: serial-frame decoder, crosspoint cell model,
// timing monitor and a cell-level reference model for random writes.
module tb_crosspoint_loader;
    localparam int ADDR_W = 12;
    localparam int FRAME4 = 1 + 2 * (ADDR_W + 2) * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crosspoint_loader_if #(.ADDR_W(ADDR_W)) c4 ();
    crosspoint_loader_if #(.ADDR_W(ADDR_W)) c1 ();
    logic xck4, xdt4, xcl4;
    logic xck1, xdt1, xcl1;

    crosspoint_loader #(.CLK_DIV(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (c4.slave),
        .xp_clk_  (xck4),
        .xp_dat   (xdt4),
        .xp_clear (xcl4)
    );

    crosspoint_loader #(.CLK_DIV(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (c1.slave),
        .xp_clk_  (xck1),
        .xp_dat   (xdt1),
        .xp_clear (xcl1)
    );

    int total = 0;
    int bad = 0;

    // crosspoint model and timing monitor for the CLK_DIV=4 instance
    bit   cells [4096];
    bit   exp_cell [4096];
    logic e_clr [$];
    logic e_dat [$];
    int   e_hi [$];
    int   e_since [$];
    int   l_len [$];
    bit   l_chg [$];
    int   n_edges = 0;
    int   rd_e = 0;
    int   rd_l = 0;

    initial begin
        logic p_clk, p_clr, p_dat, c, d, k, chg;
        int hi_n, lo_n, since, pos;
        bit lo_chg;
        logic [ADDR_W-1:0] acc;
        p_clk = 1'b1; p_clr = 1'b0; p_dat = 1'b0;
        hi_n = 0; lo_n = 0; since = 0; pos = ADDR_W + 1;
        lo_chg = 1'b0; acc = '0;
        forever begin
            @(negedge clk);
            k = xck4; c = xcl4; d = xdt4;
            chg = (c !== p_clr) || (d !== p_dat);
            if (!k && p_clk) begin
                e_clr.push_back(c);
                e_dat.push_back(d);
                e_hi.push_back(hi_n);
                e_since.push_back(chg ? 0 : since);
                n_edges++;
                if (c) pos = 0;
                else if (pos < ADDR_W) begin
                    acc[pos] = d;
                    pos++;
                end else if (pos == ADDR_W) begin
                    cells[acc] = d;
                    pos++;
                end
                lo_n = 1;
                lo_chg = 1'b0;
            end else if (!k) begin
                lo_n++;
                if (chg) lo_chg = 1'b1;
            end else if (!p_clk) begin
                l_len.push_back(lo_n);
                l_chg.push_back(lo_chg);
                hi_n = 1;
            end else begin
                hi_n++;
            end
            since = chg ? 1 : since + 1;
            p_clk = k; p_clr = c; p_dat = d;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int ones();
        int n = 0;
        for (int i = 0; i < 4096; i++) n += int'(cells[i]);
        return n;
    endfunction

    // returns at the sample just after the accepting edge
    task automatic send4(input int a, input bit d);
        @(negedge clk);
        c4.cmd_valid = 1'b1;
        c4.cmd_addr = ADDR_W'(a);
        c4.cmd_dat = d;
        for (int i = 0; i < 400 && c4.cmd_ready !== 1'b1; i++)
            @(negedge clk);
        @(posedge clk);
        #1 c4.cmd_valid = 1'b0;
    endtask

    // the current sample counts as cycle 1 after the accept edge
    task automatic wait_done4(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 400; i++) begin
            if (c4.done === 1'b1) begin
                cyc = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string tag, input int a, input bit d);
        logic [13:0] oc, od, ec, ed;
        int viol;
        @(negedge clk);
        #1;
        oc = 'x; od = 'x; viol = 0;
        ec = 14'h1;
        ed = '0;
        for (int k = 1; k <= ADDR_W; k++) ed[k] = 1'((a >> (k - 1)) & 1);
        ed[13] = d;
        if (e_clr.size() >= rd_e + 14 && l_len.size() >= rd_l + 14) begin
            for (int k = 0; k < 14; k++) begin
                oc[k] = e_clr[rd_e + k];
                od[k] = e_dat[rd_e + k];
                if (k == 0 ? e_hi[rd_e] < 4 : e_hi[rd_e + k] != 4) viol++;
                if (e_since[rd_e + k] < 4) viol++;
                if (l_len[rd_l + k] != 4 || l_chg[rd_l + k]) viol++;
            end
            rd_e += 14;
            rd_l += 14;
        end else begin
            viol = 99;
        end
        check({tag, "_clear"}, 32'(oc), 32'(ec));
        check({tag, "_dat"}, 32'(od), 32'(ed));
        check({tag, "_timing"}, viol, 0);
    endtask

    task automatic write4(input string tag, input int a, input bit d);
        int cyc;
        send4(a, d);
        wait_done4(cyc);
        check({tag, "_done_cyc"}, cyc, FRAME4);
        check_frame(tag, a, d);
        exp_cell[a] = d;
        check({tag, "_cell"}, 32'(cells[a]), 32'(exp_cell[a]));
    endtask

    task automatic bad_cmd4(input string tag, input int a);
        int base, anom;
        base = n_edges;
        send4(a, 1'b1);
        check({tag, "_err"}, {c4.err, c4.done, c4.cmd_ready, xck4}, 4'b1011);
        anom = 0;
        for (int i = 2; i <= 150; i++) begin
            @(posedge clk);
            #1;
            if (c4.err !== 1'b0 || c4.done !== 1'b0) anom++;
            if (c4.cmd_ready !== 1'b1 || xck4 !== 1'b1) anom++;
        end
        check({tag, "_quiet"}, anom, 0);
        check({tag, "_edges"}, n_edges - base, 0);
    endtask

    initial begin
        logic [13:0] dv, cv, ev;
        int n, done_at, cyc, base;
        logic pc;
        c4.cmd_valid = 1'b0; c4.cmd_addr = '0; c4.cmd_dat = 1'b0;
        c1.cmd_valid = 1'b0; c1.cmd_addr = '0; c1.cmd_dat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset4", {c4.cmd_ready, c4.done, c4.err, xck4, xdt4, xcl4},
              6'b100100);
        check("reset1", {c1.cmd_ready, c1.done, c1.err, xck1, xdt1, xcl1},
              6'b100100);
        @(negedge clk);
        rst_n = 1'b1;

        // CLK_DIV=1 frame, address 0x005, data 1
        @(negedge clk);
        c1.cmd_valid = 1'b1; c1.cmd_addr = 12'h005; c1.cmd_dat = 1'b1;
        @(posedge clk);
        #1 c1.cmd_valid = 1'b0;
        n = 0; pc = 1'b1; done_at = -1; dv = '0; cv = '0;
        for (int i = 1; i <= 40; i++) begin
            if (pc === 1'b1 && xck1 === 1'b0) begin
                if (n < 14) begin
                    dv[n] = xdt1;
                    cv[n] = xcl1;
                end
                n++;
            end
            pc = xck1;
            if (c1.done === 1'b1 && done_at < 0) done_at = i;
            @(posedge clk);
            #1;
        end
        ev = '0;
        for (int k = 1; k <= ADDR_W; k++) ev[k] = 1'((5 >> (k - 1)) & 1);
        ev[13] = 1'b1;
        check("div1_edges", n, 14);
        check("div1_clear", 32'(cv), 32'h1);
        check("div1_dat", 32'(dv), 32'(ev));
        check("div1_done", done_at, 29);

        // integration with the crosspoint cell model
        write4("w9a", 9, 1'b1);
        check("w9a_ones", ones(), 1);
        write4("w9b", 9, 1'b0);
        check("w9b_ones", ones(), 0);

        bad_cmd4("oor", 2352);

        // back-to-back with cmd_valid held throughout
        base = n_edges;
        @(negedge clk);
        c4.cmd_valid = 1'b1; c4.cmd_addr = 12'd0; c4.cmd_dat = 1'b1;
        @(posedge clk);
        #1 c4.cmd_addr = 12'd18;
        wait_done4(cyc);
        check("b2b_done1", cyc, FRAME4);
        check("b2b_ready", c4.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        check("b2b_next", {c4.cmd_ready, xck4, xcl4}, 3'b011);
        c4.cmd_valid = 1'b0;
        wait_done4(cyc);
        check("b2b_done2", cyc, FRAME4);
        check_frame("b2b_f1", 0, 1'b1);
        check_frame("b2b_f2", 18, 1'b1);
        exp_cell[0] = 1'b1;
        exp_cell[18] = 1'b1;
        check("b2b_edges", n_edges - base, 28);
        check("b2b_cells", {cells[0], cells[18]}, 2'b11);

        // reset in the middle of a frame
        base = n_edges;
        send4(7, 1'b1);
        for (int i = 0; i < 400 && n_edges < base + 5; i++)
            @(posedge clk);
        check("mid_edge5", n_edges - base >= 5, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst", {c4.cmd_ready, xck4, xdt4, xcl4}, 4'b1100);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        rd_e = e_clr.size();
        rd_l = l_len.size();
        write4("post_rst", 9, 1'b1);
        check("post_rst_c7", 32'(cells[7]), 32'(exp_cell[7]));

        // random writes against the cell-level reference
        for (int r = 0; r < 8; r++) begin
            int a;
            bit d;
            a = int'($urandom_range(0, 2799));
            d = 1'($urandom_range(0, 1));
            if (a <= 2351) write4($sformatf("rnd%0d", r), a, d);
            else bad_cmd4($sformatf("rnd%0d", r), a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
